// File: rtl/move_drain_if.sv
// Handshake bundle between move_drain, the muxed square FIFOs and the search/eval consumer.
interface move_drain_if #(
  parameter int SEL_W = 6
);
  logic [SEL_W-1:0] src_sel;
  logic             src_empty;
  logic             src_rden;
  logic [151:0]     src_q;
  logic             mv_valid;
  logic             mv_ready;
  logic [18:0]      mv_data;

  modport master (
    output src_sel, src_rden, mv_valid, mv_data,
    input  src_empty, src_q, mv_ready
  );

  modport slave (
    input  src_sel, src_rden, mv_valid, mv_data,
    output src_empty, src_q, mv_ready
  );
endinterface

// File: rtl/move_drain.sv
// Drains square FIFOs 0..NUM_SRC-1 in order, unpacking eight 19-bit slots per word into single moves.
// Define MOVE_DRAIN_CAPTURE_CNT_EN to add the capture_count output.
module move_drain #(
  parameter int NUM_SRC = 64,
  parameter int SEL_W   = 6,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  move_drain_if.master     bus,
  output logic             busy,
  output logic             drain_done,
  output logic [CNT_W-1:0] move_count
`ifdef MOVE_DRAIN_CAPTURE_CNT_EN
  ,
  output logic [CNT_W-1:0] capture_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_READ   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNPACK = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SRC - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};

  state_t       state_r;
  logic [151:0] word_r;
  logic [2:0]   slot_r;
  logic [18:0]  cur_slot_s;
  logic [18:0]  nxt_slot_s;

  function automatic logic [18:0] slot_of(input logic [151:0] w, input logic [2:0] k);
    slot_of = w[19*k +: 19];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Current slot and the one after it, so the next move can be registered on the advance edge.
  always_comb begin
    cur_slot_s = slot_of(word_r, slot_r);
    nxt_slot_s = slot_of(word_r, slot_r - 3'd1);
  end

  // Drain sequencer with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      word_r        <= 152'd0;
      slot_r        <= 3'd7;
      bus.src_sel   <= '0;
      bus.src_rden  <= 1'b0;
      bus.mv_valid  <= 1'b0;
      bus.mv_data   <= 19'd0;
      busy          <= 1'b0;
      drain_done    <= 1'b0;
      move_count    <= '0;
`ifdef MOVE_DRAIN_CAPTURE_CNT_EN
      capture_count <= '0;
`endif
    end else begin
      drain_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_SCAN;
            bus.src_sel <= '0;
            move_count  <= '0;
            busy        <= 1'b1;
`ifdef MOVE_DRAIN_CAPTURE_CNT_EN
            capture_count <= '0;
`endif
          end
        end
        ST_SCAN: begin
          if (!bus.src_empty) begin
            state_r      <= ST_READ;
            bus.src_rden <= 1'b1;
          end else if (bus.src_sel == LAST_SEL) begin
            state_r    <= ST_FIN;
            drain_done <= 1'b1;
          end else begin
            bus.src_sel <= bus.src_sel + SEL_ONE;
          end
        end
        ST_READ: begin
          bus.src_rden <= 1'b0;
          state_r      <= ST_WAIT;
        end
        // q is valid now; present slot 7 immediately so UNPACK starts with it on the bus.
        ST_WAIT: begin
          word_r       <= bus.src_q;
          slot_r       <= 3'd7;
          state_r      <= ST_UNPACK;
          bus.mv_valid <= ~bus.src_q[151];
          if (!bus.src_q[151]) begin
            bus.mv_data <= bus.src_q[151:133];
          end
        end
        ST_UNPACK: begin
          if (!(bus.mv_valid && !bus.mv_ready)) begin
            if (bus.mv_valid) begin
              move_count <= sat_inc(move_count);
`ifdef MOVE_DRAIN_CAPTURE_CNT_EN
              if (cur_slot_s[12]) begin
                capture_count <= sat_inc(capture_count);
              end
`endif
            end
            // After slot 0 rescan the same source so it is drained until empty.
            if (slot_r == 3'd0) begin
              state_r      <= ST_SCAN;
              bus.mv_valid <= 1'b0;
            end else begin
              slot_r       <= slot_r - 3'd1;
              bus.mv_valid <= ~nxt_slot_s[18];
              if (!nxt_slot_s[18]) begin
                bus.mv_data <= nxt_slot_s;
              end
            end
          end
        end
        ST_FIN: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          bus.src_rden <= 1'b0;
          bus.mv_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_drain.sv
// Randomised bench for move_drain: FIFO/consumer models plus a spec-level expected-move list.
`timescale 1ns/1ps
module tb_move_drain;
  localparam int NUM_SRC = 64;
  localparam int SEL_W   = 6;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             drain_done;
  logic [CNT_W-1:0] move_count;
`ifdef MOVE_DRAIN_CAPTURE_CNT_EN
  logic [CNT_W-1:0] capture_count;
`endif

  move_drain_if #(.SEL_W(SEL_W)) bus ();

  move_drain #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .drain_done(drain_done), .move_count(move_count)
`ifdef MOVE_DRAIN_CAPTURE_CNT_EN
    , .capture_count(capture_count)
`endif
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  logic [151:0] fifo[NUM_SRC][$];
  logic [18:0]  exp_q[$];
  int           exp_moves, exp_caps;
  int           rden_cnt = 0;
  int           last_rden_sel = -1;
  int           ready_mode = 0;
  logic [151:0] q_next;
  bit           q_load = 1'b0;
  bit           cand, stall_prev;
  logic [18:0]  cand_data, stall_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every valid slot in FIFO order, slots 7 down to 0 within each word.
  function automatic void build_expected();
    exp_q.delete();
    exp_moves = 0;
    exp_caps  = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int w = 0; w < fifo[s].size(); w++) begin
        for (int k = 7; k >= 0; k--) begin
          logic [18:0] sl;
          sl = 19'(fifo[s][w] >> (19 * k));
          if (!sl[18]) begin
            exp_q.push_back(sl);
            exp_moves++;
            if (sl[12]) exp_caps++;
          end
        end
      end
    end
  endfunction

  function automatic logic [151:0] rand_word(input int inv_pct);
    logic [151:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      logic [18:0] s;
      s = 19'($urandom());
      s[18] = ($urandom_range(0, 99) < inv_pct);
      w[19*k +: 19] = s;
    end
    return w;
  endfunction

  // Consumer ready pattern.
  initial begin
    bus.mv_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.mv_ready = 1'b1;
        1:       bus.mv_ready = ~bus.mv_ready;
        default: bus.mv_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Non-showahead FIFO model: q valid only in the cycle after rden, garbage otherwise.
  initial begin
    bus.src_q     = '0;
    bus.src_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.src_rden === 1'b1) begin
        rden_cnt++;
        last_rden_sel = int'(bus.src_sel);
        check("rden_nonempty", 32'(fifo[bus.src_sel].size() != 0), 32'd1);
        if (fifo[bus.src_sel].size() != 0) begin
          q_next = fifo[bus.src_sel].pop_front();
          q_load = 1'b1;
        end
      end
      @(posedge clk); #1;
      bus.src_q     = q_load ? q_next : 152'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      q_load        = 1'b0;
      bus.src_empty = (fifo[bus.src_sel].size() == 0);
    end
  end

  // Move monitor: order against the expected list, plus hold-while-stalled.
  initial begin
    cand = 1'b0;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_prev && !reset) begin
        check("hold_valid", 32'(bus.mv_valid), 32'd1);
        check("hold_data", 32'(bus.mv_data), 32'(stall_data));
      end
      cand       = !reset && bus.mv_valid === 1'b1 && bus.mv_ready === 1'b1;
      cand_data  = bus.mv_data;
      stall_prev = !reset && bus.mv_valid === 1'b1 && bus.mv_ready === 1'b0;
      stall_data = bus.mv_data;
      @(posedge clk);
      if (cand && !reset) begin
        check("move_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("move_data", 32'(cand_data), 32'(exp_q.pop_front()));
      end
      if (reset) stall_prev = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},   32'(bus.src_sel), 32'd0);
    check({tag, "_rden"},  32'(bus.src_rden), 32'd0);
    check({tag, "_valid"}, 32'(bus.mv_valid), 32'd0);
    check({tag, "_data"},  32'(bus.mv_data), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(drain_done), 32'd0);
    check({tag, "_count"}, 32'(move_count), 32'd0);
`ifdef MOVE_DRAIN_CAPTURE_CNT_EN
    check({tag, "_cap"},   32'(capture_count), 32'd0);
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_pass(input string tag, input int dup_at, input int bound,
                         output int first_v, output int done_at);
    int dn;
    build_expected();
    rden_cnt = 0;
    first_v  = 0;
    done_at  = 0;
    dn       = 0;
    pulse_start();
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      start = (n == dup_at);
      if (n == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (first_v == 0 && bus.mv_valid === 1'b1) first_v = n;
      if (drain_done === 1'b1) begin
        dn++;
        done_at = n;
        break;
      end
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (drain_done === 1'b1) dn++;
    end
    check({tag, "_done_cnt"},  32'(dn), 32'd1);
    check({tag, "_count"},     32'(move_count), 32'(exp_moves));
    check({tag, "_left"},      32'(exp_q.size()), 32'd0);
    check({tag, "_busy_end"},  32'(busy), 32'd0);
`ifdef MOVE_DRAIN_CAPTURE_CNT_EN
    check({tag, "_cap"},       32'(capture_count), 32'(exp_caps));
`endif
  endtask

  initial begin
    int fv, da, found;
    logic [151:0] w;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    reset = 1'b0;

    // All sources empty: 64 scan cycles then FIN.
    do_pass("empty", 0, 200, fv, da);
    check("empty_done_lat", 32'(da), 32'd65);
    check("empty_rden", 32'(rden_cnt), 32'd0);

    // One valid move in source 12.
    fifo[12].push_back({19'h001C5, {7{19'h40000}}});
    do_pass("single", 0, 300, fv, da);
    check("single_rden", 32'(rden_cnt), 32'd1);
    check("single_sel", 32'(last_rden_sel), 32'd12);

    // Two full words in source 0 with toggling ready; a second start mid-pass is ignored.
    ready_mode = 1;
    fifo[0].push_back(rand_word(0));
    fifo[0].push_back(rand_word(0));
    do_pass("toggle", 20, 300, fv, da);
    check("toggle_latency", 32'(fv), 32'd4);
    check("toggle_rden", 32'(rden_cnt), 32'd2);

    // Reset while slot 4 is presented; the next pass drains what is left.
    ready_mode = 0;
    w = '0;
    for (int k = 0; k < 8; k++) w[19*k +: 19] = 19'(32'h100 + k);
    fifo[0].push_back(w);
    fifo[3].push_back(rand_word(30));
    build_expected();
    pulse_start();
    found = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.mv_valid === 1'b1 && bus.mv_data === 19'h00104) begin
        found = 1;
        break;
      end
    end
    check("rst_slot4_reached", 32'(found), 32'd1);
    #3 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1 reset = 1'b0;
    do_pass("after_rst", 0, 400, fv, da);
    check("after_rst_rden", 32'(rden_cnt), 32'd1);

    // Random contents across random sources with random backpressure.
    ready_mode = 2;
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < 5; j++) begin
        int s;
        s = $urandom_range(0, NUM_SRC - 1);
        repeat ($urandom_range(1, 2)) fifo[s].push_back(rand_word($urandom_range(0, 100)));
      end
      do_pass("random", 0, 3000, fv, da);
    end

`ifdef MOVE_DRAIN_CAPTURE_CNT_EN
    ready_mode = 0;
    fifo[5].push_back({19'h01041, 19'h00082, 19'h010C3, 19'h01104, 19'h00145, {3{19'h40000}}});
    do_pass("capture", 0, 300, fv, da);
    check("capture_cnt", 32'(capture_count), 32'd3);
    check("capture_moves", 32'(move_count), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
